// File: rtl/key_cmd_queue.sv
// key_cmd_queue
// Turns per-key one-pulse inputs from the keyboard block into an ordered
// stream of game command codes and buffers them in a small circular FIFO
// with a valid/ready handshake toward the game-control FSM.
//
// Ports:
//   key_sensitive_clk  block clock
//   rst                asynchronous, active-high reset
//   key_press_1plus    key pulses; bit i maps to command code i
//   flush              synchronous clear of queue and pending events
//   cmd_ready          consumer accepts cmd this cycle
//   cmd_valid          head entry present
//   cmd                head command code
//   count              FIFO occupancy, 0..DEPTH
//   pending_any        at least one event waits for FIFO space
//   drop_cnt           saturating count of merged (lost) events
//
// Optional feature: define KEY_CMD_STATS_EN to build the drop_cnt counter;
// otherwise drop_cnt is tied to 0.

module key_cmd_queue #(
  parameter int unsigned KEY_PRESS_LEN = 7,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CMD_W         = 3
) (
  input  logic                       key_sensitive_clk,
  input  logic                       rst,
  input  logic [KEY_PRESS_LEN-1:0]   key_press_1plus,
  input  logic                       flush,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [CMD_W-1:0]           cmd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pending_any,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 8;

  logic [KEY_PRESS_LEN-1:0] key_q;
  logic [KEY_PRESS_LEN-1:0] pending;
  logic [KEY_PRESS_LEN-1:0] pending_n;
  logic [KEY_PRESS_LEN-1:0] rise;
  logic [KEY_PRESS_LEN-1:0] request;
  logic [KEY_PRESS_LEN-1:0] grant_vec;
  logic [CMD_W-1:0]         grant_idx;
  logic                     found;
  logic                     pop;
  logic                     space;
  logic                     push;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic [CMD_W-1:0] head_n;

  logic [CMD_W-1:0] mem [DEPTH];

  // Edge detect, fixed-priority grant (lowest index first) and next-state.
  always_comb begin
    rise      = key_press_1plus & ~key_q;
    request   = pending | rise;
    pop       = cmd_valid & cmd_ready;
    space     = (count < CNT_W'(DEPTH)) | pop;
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (space) begin
      for (int i = 0; i < int'(KEY_PRESS_LEN); i++) begin
        if (!found && request[i]) begin
          found        = 1'b1;
          grant_idx    = CMD_W'(i);
          grant_vec[i] = 1'b1;
        end
      end
    end
    push      = found & ~flush;

    pending_n = request & ~grant_vec;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    if (flush) begin
      // Flush wins over any push or pop in the same cycle.
      pending_n = '0;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      count_n   = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
    end

    // Next head: the entry being written if it lands at the new read slot.
    if (push && (wr_ptr == rd_ptr_n)) head_n = grant_idx;
    else                              head_n = mem[rd_ptr_n];
  end

  // Control state and registered outputs.
  always_ff @(posedge key_sensitive_clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_valid   <= 1'b0;
      cmd         <= '0;
      pending_any <= 1'b0;
    end else begin
      key_q       <= key_press_1plus;
      pending     <= pending_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      cmd_valid   <= (count_n != '0);
      pending_any <= |pending_n;
      if (count_n != '0) cmd <= head_n;
    end
  end

  // Command storage; contents are not reset.
  always_ff @(posedge key_sensitive_clk) begin
    if (push) mem[wr_ptr] <= grant_idx;
  end

`ifdef KEY_CMD_STATS_EN
  localparam int unsigned SUM_W = DROP_W + $clog2(KEY_PRESS_LEN + 1);

  logic [KEY_PRESS_LEN-1:0] merged;
  logic [SUM_W-1:0]         drop_sum;
  logic [DROP_W-1:0]        drop_q;
  logic [DROP_W-1:0]        drop_n;

  // A rise on an already-pending bit is merged and counts as one lost event.
  always_comb begin
    merged   = rise & pending;
    drop_sum = SUM_W'(drop_q);
    for (int i = 0; i < int'(KEY_PRESS_LEN); i++) begin
      drop_sum = drop_sum + SUM_W'(merged[i]);
    end
    if (drop_sum > SUM_W'({DROP_W{1'b1}})) drop_n = {DROP_W{1'b1}};
    else                                   drop_n = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge key_sensitive_clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_n;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_key_cmd_queue.sv
// Scoreboard bench for key_cmd_queue: stimulus pushes expected command codes,
// a monitor pops and compares on every accepted handshake.

module tb_key_cmd_queue;

  localparam int unsigned KEY_PRESS_LEN = 7;
  localparam int unsigned DEPTH         = 4;
  localparam int unsigned CMD_W         = 3;

`ifdef KEY_CMD_STATS_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic                     key_sensitive_clk = 1'b0;
  logic                     rst;
  logic [KEY_PRESS_LEN-1:0] key_press_1plus;
  logic                     flush;
  logic                     cmd_ready;
  logic                     cmd_valid;
  logic [CMD_W-1:0]         cmd;
  logic [$clog2(DEPTH):0]   count;
  logic                     pending_any;
  logic [7:0]               drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  always #5 key_sensitive_clk = ~key_sensitive_clk;

  key_cmd_queue #(
    .KEY_PRESS_LEN(KEY_PRESS_LEN),
    .DEPTH        (DEPTH),
    .CMD_W        (CMD_W)
  ) dut (
    .key_sensitive_clk(key_sensitive_clk),
    .rst              (rst),
    .key_press_1plus  (key_press_1plus),
    .flush            (flush),
    .cmd_ready        (cmd_ready),
    .cmd_valid        (cmd_valid),
    .cmd              (cmd),
    .count            (count),
    .pending_any      (pending_any),
    .drop_cnt         (drop_cnt)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge key_sensitive_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge key_sensitive_clk);
  endtask

  // Monitor: every accepted handshake must match the scoreboard head.
  initial begin
    forever begin
      @(negedge key_sensitive_clk);
      if (!rst && !flush && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_order: got cmd %0d, expected no entry", cmd);
        end else begin
          check("pop_order", int'(cmd), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2};

    rst             = 1'b1;
    key_press_1plus = '0;
    flush           = 1'b0;
    cmd_ready       = 1'b0;

    // Reset state
    repeat (2) @(posedge key_sensitive_clk);
    smp();
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_pending", int'(pending_any), 0);
    check("rst_drop", int'(drop_cnt), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // LEFT held for 3 cycles gives exactly one entry
    key_press_1plus = 7'b0000100;
    exp_q.push_back(2);
    cyc();
    smp();
    check("t1_count", int'(count), 1);
    check("t1_valid", int'(cmd_valid), 1);
    check("t1_cmd", int'(cmd), 2);
    cyc();
    cyc();
    key_press_1plus = '0;
    smp();
    check("t1_single_entry", int'(count), 1);
    cyc();
    cmd_ready = 1'b1;
    cyc();
    cmd_ready = 1'b0;
    smp();
    check("t1_drained_count", int'(count), 0);
    check("t1_drained_valid", int'(cmd_valid), 0);

    // UP, RIGHT, SPACE simultaneously: serialised 0, 3, 4
    cyc();
    key_press_1plus = 7'b0011001;
    cmd_ready       = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(3);
    exp_q.push_back(4);
    cyc();
    key_press_1plus = '0;
    smp();
    check("t2_cmd_first", int'(cmd), 0);
    check("t2_pend_c1", int'(pending_any), 1);
    cyc();
    smp();
    check("t2_pend_c2", int'(pending_any), 1);
    check("t2_count_c2", int'(count), 1);
    cyc();
    smp();
    check("t2_pend_c3", int'(pending_any), 0);
    cyc();
    smp();
    check("t2_empty", int'(cmd_valid), 0);
    cyc();
    cmd_ready = 1'b0;

    // DOWN x5 into a 4-deep FIFO, then a merged DOWN, then pop/refill
    for (int i = 0; i < 5; i++) begin
      key_press_1plus = 7'b0000010;
      exp_q.push_back(1);
      cyc();
      key_press_1plus = '0;
      cyc();
    end
    smp();
    check("t3_full_count", int'(count), 4);
    check("t3_full_pend", int'(pending_any), 1);
    cyc();
    key_press_1plus = 7'b0000010;
    cyc();
    key_press_1plus = '0;
    smp();
    check("t4_drop_cnt", int'(drop_cnt), EXP_DROP);
    check("t4_count", int'(count), 4);
    check("t4_pend", int'(pending_any), 1);
    cyc();
    cmd_ready = 1'b1;
    smp();
    check("t3_pre_pop_count", int'(count), 4);
    cyc();
    cmd_ready = 1'b0;
    smp();
    check("t3_pop_refill_count", int'(count), 4);
    check("t3_pop_refill_pend", int'(pending_any), 0);
    cyc();
    cmd_ready = 1'b1;
    repeat (4) cyc();
    cmd_ready = 1'b0;
    smp();
    check("t3_drain_count", int'(count), 0);
    check("t3_all_down_popped", exp_q.size(), 0);

    // 3 queued + 1 pending, then flush together with cmd_ready
    cyc();
    key_press_1plus = 7'b0001111;
    cyc();
    key_press_1plus = '0;
    cyc();
    cyc();
    flush     = 1'b1;
    cmd_ready = 1'b1;
    smp();
    check("t5_pre_count", int'(count), 3);
    check("t5_pre_pend", int'(pending_any), 1);
    cyc();
    flush     = 1'b0;
    cmd_ready = 1'b0;
    smp();
    check("t5_flush_count", int'(count), 0);
    check("t5_flush_valid", int'(cmd_valid), 0);
    check("t5_flush_pend", int'(pending_any), 0);

    // Continuous push/pop across pointer wrap, then reset mid-stream
    for (int i = 0; i < 10; i++) begin
      cyc();
      key_press_1plus = KEY_PRESS_LEN'(1) << seq[i];
      cmd_ready       = 1'b1;
      exp_q.push_back(seq[i]);
      smp();
      if (i > 0) check("t6_stream_count", int'(count), 1);
    end
    cyc();
    key_press_1plus = '0;
    rst             = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_valid", int'(cmd_valid), 0);
    check("t6_rst_pend", int'(pending_any), 0);
    cyc();
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    smp();
    check("t6_no_cmd_after_rst", int'(cmd_valid), 0);
    cyc();
    cmd_ready = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Converts the per-key one-pulse outputs of the keyboard block into an ordered stream of 3-bit game commands and buffers them in a small FIFO for the Tetris game-control FSM. Sits directly downstream of the keyboard block, sampling `key_press_1plus` on `key_sensitive_clk`. Simultaneous key events are serialised in fixed priority. A valid/ready handshake decouples key arrival from the game FSM's consumption rate.

## Interface
Parameters:
- `KEY_PRESS_LEN`, 7, number of key pulse inputs; bit i maps to command code i.
- `DEPTH`, 4, FIFO entries; must be a power of two, minimum 2.
- `CMD_W`, 3, command code width; must satisfy 2^CMD_W ≥ KEY_PRESS_LEN.

Ports:
- `key_sensitive_clk`  in  1  block clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `key_press_1plus`  in  KEY_PRESS_LEN  key pulses from the keyboard block; each pulse is high for ≥1 `key_sensitive_clk` cycle.
- `flush`  in  1  synchronous clear of the queue and pending events.
- `cmd_ready`  in  1  consumer accepts `cmd` this cycle.
- `cmd_valid`  out  1  head entry present.
- `cmd`  out  CMD_W  head command code: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 SPACE, 5 RIGHT_1, 6 RIGHT_3.
- `count`  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `pending_any`  out  1  at least one event waits for FIFO space.
- `drop_cnt`  out  8  merged/lost event counter (see Configuration).

## Operation
- Edge detect: register `key_q` ← `key_press_1plus` each cycle; `rise` = `key_press_1plus & ~key_q`. A pulse held for several cycles produces exactly one event.
- `request` = `pending | rise`. If FIFO has space (`count < DEPTH` or a pop occurs this cycle), grant the lowest-index set bit of `request`; write its index as `cmd` at `wr_ptr`.
- `pending` ← `request & ~grant`. At most one push per cycle; remaining bits wait in priority order, lowest index first.
- A `rise` on a bit already set in `pending` merges into it. That is one lost event.
- Pop: `cmd_valid & cmd_ready`; `rd_ptr` advances. `cmd_ready` while empty is ignored.
- FIFO is circular: `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap from DEPTH-1 to 0. `count` is incremented on push-only, decremented on pop-only, and unchanged on push+pop.
- No bypass: an entry pushed into an empty FIFO is visible the following cycle.
- `flush` clears `pending`, both pointers and `count`, and overrides push and pop in the same cycle. It does not touch `key_q`, so keys held through a flush do not re-fire. It does not clear `drop_cnt`.
- `cmd` is `mem[rd_ptr]`. Its value is don't-care when `cmd_valid`=0.

## Timing
- Reset values: `key_q`=0, `pending`=0, pointers=0, `count`=0, `cmd_valid`=0, `cmd`=0, `pending_any`=0, `drop_cnt`=0. Storage contents are not reset.
- Because `key_q` resets to 0, a key input high at reset release generates one event.
- Latency: `rise` in cycle k with space available gives `cmd_valid`=1 and the command at the head in cycle k+1.
- Full FIFO with a pop in cycle k: a pending or rising event is pushed in cycle k and `count` stays DEPTH.
- Full FIFO without a pop: events stay in `pending` and `pending_any`=1. They drain one per cycle as space frees.
- Reset assertion mid-operation clears all state immediately. No command is emitted until a new `rise` occurs.

## Configuration
- `KEY_CMD_STATS_EN` defined:
  - `drop_cnt` increments by the number of bits in `rise & pending` each cycle.
  - It saturates at 255 and is cleared only by `rst`.
- `KEY_CMD_STATS_EN` undefined: `drop_cnt` is tied to 0 and its logic is not built. All other behaviour is identical.

## Test plan
- Reset, then LEFT (bit 2) pulse for 3 cycles with `cmd_ready`=0 → exactly one entry; `cmd`=2, `count`=1 one cycle after the rise.
- UP, RIGHT and SPACE rise in the same cycle, `cmd_ready`=1 → outputs appear on consecutive cycles: `cmd` 0, then 3, then 4; `pending_any` is 1 for the first 2 cycles.
- `cmd_ready`=0; 5 single-key events (DOWN ×5) into DEPTH=4 → `count`=4 and `pending_any`=1. Then one pop → DOWN enters on the same cycle and `count` stays 4.
- `cmd_ready`=0, FIFO full with DOWN pending; DOWN rises again → with `KEY_CMD_STATS_EN`, `drop_cnt`=1; without it, `drop_cnt`=0. In both builds only 5 DOWN entries are ever popped.
- 3 entries queued plus 1 pending; assert `flush` together with `cmd_ready` → next cycle `count`=0, `cmd_valid`=0, `pending_any`=0.
- Push and pop continuously for 10 cycles → pointers wrap and commands come out in input order; assert `rst` mid-stream → `count`=0 immediately.
